// File: rtl/gates_input_driver.sv
// gates_input_driver: synchronises and debounces board inputs and drives
// gates.a in manual (switch-follow) or auto (timer/button sweep) mode.
module gates_input_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       step_btn,
    input  logic       mode,
    output logic [1:0] a,
    output logic       a_stb,
    output logic       auto_active
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(STEP_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(STEP_CYCLES - 1);

    typedef enum logic {MANUAL, AUTO} state_t;

    // bit order: {mode, step_btn, sw[1:0]}
    logic [3:0]          sync_1;
    logic [3:0]          sync_2;
    logic [2:0]          deb;
    logic [2:0][DW-1:0]  cnt;
    logic                btn_prev;

    state_t              state;
    state_t              state_next;
    logic [TW-1:0]       timer;
    logic [TW-1:0]       timer_next;
    logic [1:0]          a_next;

    logic                mode_sync;
    logic [1:0]          sw_deb;
    logic                btn_rise;

    assign mode_sync = sync_2[3];
    assign sw_deb    = deb[1:0];
    assign btn_rise  = deb[2] & ~btn_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1   <= '0;
            sync_2   <= '0;
            deb      <= '0;
            cnt      <= '0;
            btn_prev <= 1'b0;
        end else begin
            sync_1   <= {mode, step_btn, sw};
            sync_2   <= sync_1;
            btn_prev <= deb[2];
            for (int i = 0; i < 3; i++) begin
                if (sync_2[i] != deb[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        deb[i] <= sync_2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + DW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // A button step restarts the dwell and wins over a same-cycle expiry.
    always_comb begin
        state_next = state;
        a_next     = a;
        timer_next = '0;
        unique case (state)
            MANUAL: begin
                if (mode_sync) begin
                    state_next = AUTO;
                end else begin
                    a_next = sw_deb;
                end
            end
            AUTO: begin
                if (!mode_sync) begin
                    state_next = MANUAL;
                end else if (btn_rise) begin
                    a_next = a + 2'd1;
                end else if (timer == T_LAST) begin
                    a_next = a + 2'd1;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: state_next = MANUAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MANUAL;
            timer       <= '0;
            a           <= 2'b00;
            a_stb       <= 1'b0;
            auto_active <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            a           <= a_next;
            a_stb       <= (a_next != a);
            auto_active <= (state_next == AUTO);
        end
    end

endmodule

// File: doc/gates_input_driver.md
# gates_input_driver

Upstream stage for the `gates` block: conditions the two board switches that drive the gate-array input `a[1:0]`, and can also sweep `a` through all four input combinations on its own. It synchronises and debounces the raw switch and push-button inputs, and supports two modes:
- manual: `a` follows the switches;
- auto: `a` counts 00→01→10→11→00 on a timer or on each button press.

Every change of `a` is flagged with a one-cycle strobe, so downstream logic can sample the `gates` output `x[7:0]`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles an input must hold a new level before it is accepted (≥2). Board build overrides to 500000.
- `STEP_CYCLES`, default 8: auto-mode dwell, in clocks, per value of `a` (≥2).

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sw`  in  2: raw switch levels, asynchronous.
- `step_btn`  in  1: raw push-button, asynchronous, active-high.
- `mode`  in  1: raw mode switch, asynchronous; 0 = manual, 1 = auto.
- `a`  out  2: registered drive to `gates.a`.
- `a_stb`  out  1: high for exactly one cycle, on the cycle in which `a` first shows a new value.
- `auto_active`  out  1: registered; high while in AUTO state.

## Operation
Synchronisation:
- `sw[1:0]`, `step_btn` and `mode` each pass through a 2-flop synchroniser.

Debounce (per bit of `sw`, and for `step_btn`):
- One debounced register and one counter per input.
- While the synchronised value ≠ debounced value: the counter increments.
- When the counter = `DEBOUNCE_CYCLES-1` and the values still differ: debounced value ← synchronised value, and the counter clears.
- Any cycle with equal values clears the counter.
- `mode` is synchronised only; it is not debounced.

State machine (2 states):
- MANUAL (reset state): `a` ← debounced `sw` every cycle. `step_btn` is ignored. The step timer is held at 0.
- MANUAL→AUTO when synchronised `mode` = 1. On the transition: `a` holds its value, and timer ← 0.
- AUTO: the timer counts 0..`STEP_CYCLES-1`. At `STEP_CYCLES-1`: `a` ← `a`+1 (2-bit wrap, 11→00), and timer ← 0.
- In AUTO, a rising edge of debounced `step_btn` (debounced level 1, previous cycle 0) does: `a` ← `a`+1, timer ← 0. This takes priority over timer expiry in the same cycle; only a single increment occurs.
- AUTO→MANUAL when synchronised `mode` = 0. `a` then loads debounced `sw` on the following cycle.
- `a_stb` is registered and set on the same edge that loads `a`, only when the new value ≠ the old value. No strobe is produced when `a` is reloaded with an identical value.

## Timing
Reset values (`rst` high at a rising edge, effective on that edge):
- `a` = 00, `a_stb` = 0, `auto_active` = 0.
- Synchronisers, debounced registers, counters and timer all = 0. State = MANUAL.
- Reset mid-operation (any state, any counter value) returns everything to these values on the next edge. No strobe is emitted by reset.

Switch latency:
- Count the first edge that samples a new raw `sw` level as edge 1.
- Debounced value updates on edge `DEBOUNCE_CYCLES+2`; `a` and `a_stb` update on edge `DEBOUNCE_CYCLES+3`. With the default of 4, this is edge 7.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never reaches `a`.

Button latency:
- A clean press changes `a` on edge `DEBOUNCE_CYCLES+3` after first sample.
- One increment per press; holding the button produces no repeats.

Mode latency:
- `auto_active` rises or falls on edge 3 after first sample of the new `mode` level.

Auto step rate:
- Consecutive timer-driven changes of `a` are exactly `STEP_CYCLES` edges apart.
- The first timer-driven change occurs `STEP_CYCLES` edges after `auto_active` rises, or after the last button step.

Simultaneous events:
- Debounced `sw` changing during AUTO has no effect on `a` until MANUAL is re-entered.

## Test plan
Benches use the defaults: `DEBOUNCE_CYCLES`=4, `STEP_CYCLES`=8.
- Reset with `sw`=11 held: `rst` high 3 cycles → during reset `a`=00, `a_stb`=0, `auto_active`=0. After release, `a`=11 on edge 7 (counting the first post-reset edge as edge 1), with one `a_stb` pulse.
- Bounce: from `a`=00, `sw[0]` toggles every 2 cycles for 20 cycles then stays 1 → `a` changes exactly once, to 01, on edge 7 after the final transition. Exactly one `a_stb`.
- Auto sweep: with `a`=01, set `mode`=1 → `auto_active`=1 on edge 3. Then `a` takes 10, 11, 00, 01 at 8-cycle intervals, with exactly 4 `a_stb` pulses.
- Button step: in AUTO, a clean 10-cycle press arriving while the timer = 3 → `a` increments once; the next timer step is 8 edges later. A press whose accept edge coincides with timer expiry → a single increment.
- Return to manual: in AUTO with `a`=11 and `sw`=10, set `mode`=0 → `auto_active`=0 on edge 3, `a`=10 on edge 4, one `a_stb`. The timer no longer advances `a` for 40 cycles.
- Reset mid-auto: assert `rst` for 1 cycle while timer = 5 and `a`=10 → next edge `a`=00, `a_stb`=0, `auto_active`=0. With `mode` still 1, `auto_active` returns high on edge 3 after release.
